// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizes for the truth-table sweeper: sweep FSM states,
// vector width and the width of the settle counter and the mismatch counter.
package truth_table_sweeper_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle counter: counts cycles while enabled and flags the last settle cycle.
// A LIMIT of zero means no settle time, so the terminal flag is always high.
module truth_table_sweeper_settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (LIMIT == 0) ? 1'b1 : (r_count == TC_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight {A,B,C} vectors into a 3-input combinational stage, samples
// its F output after a settle time and scores it against an expected truth table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXPECTED      = 8'h10,
    parameter int                 SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             f_in,
    output logic             a_out,
    output logic             b_out,
    output logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_vec,
    output state_t           dbg_state
);

    localparam state_t           FIRST_ST = (SETTLE_CYCLES == 0) ? SAMPLE : HOLD;
    localparam logic [CNT_W-1:0] FAIL_MAX = CNT_W'(NUM_VEC);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

    state_t           r_state;
    logic [VEC_W-1:0] r_vec;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_fail_count;
    logic             r_ffv;
    logic [VEC_W-1:0] r_ffvec;

    state_t           w_state_nxt;
    logic [VEC_W-1:0] w_vec_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic [CNT_W-1:0] w_fail_nxt;
    logic             w_ffv_nxt;
    logic [VEC_W-1:0] w_ffvec_nxt;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic             w_timer_tc;
    logic             w_mismatch;
    logic             w_busy;

    truth_table_sweeper_settle_timer #(
        .LIMIT (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_timer_clr),
        .i_en  (w_timer_en),
        .o_tc  (w_timer_tc)
    );

    assign w_mismatch = (f_in != EXPECTED[r_vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_vec        <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_count <= '0;
            r_ffv        <= 1'b0;
            r_ffvec      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_vec        <= w_vec_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_fail_count <= w_fail_nxt;
            r_ffv        <= w_ffv_nxt;
            r_ffvec      <= w_ffvec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail_count;
        w_ffv_nxt   = r_ffv;
        w_ffvec_nxt = r_ffvec;
        w_timer_clr = 1'b1;
        w_timer_en  = 1'b0;

        // Abort wins over start and sampling; partial results are kept for inspection.
        if (abort) begin
            w_state_nxt = IDLE;
            w_pass_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_state_nxt = FIRST_ST;
                        w_vec_nxt   = '0;
                        w_pass_nxt  = 1'b0;
                        w_fail_nxt  = '0;
                        w_ffv_nxt   = 1'b0;
                    end
                end
                HOLD: begin
                    w_timer_clr = 1'b0;
                    w_timer_en  = 1'b1;
                    if (w_timer_tc) begin
                        w_state_nxt = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_fail_count < FAIL_MAX) begin
                            w_fail_nxt = r_fail_count + 1'b1;
                        end
                        if (!r_ffv) begin
                            w_ffv_nxt   = 1'b1;
                            w_ffvec_nxt = r_vec;
                        end
                    end
                    if (r_vec == VEC_LAST) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (r_fail_count == '0) && !w_mismatch;
                    end else begin
                        w_vec_nxt   = r_vec + 1'b1;
                        w_state_nxt = FIRST_ST;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // The vector is only presented while sweeping; the stage sees 000 otherwise.
    assign w_busy = (r_state == HOLD) || (r_state == SAMPLE);

    assign busy             = w_busy;
    assign a_out            = w_busy & r_vec[2];
    assign b_out            = w_busy & r_vec[1];
    assign c_out            = w_busy & r_vec[0];
    assign done             = r_done;
    assign pass             = r_pass;
    assign fail_count       = r_fail_count;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 2 and settle 0) whose F
// input comes from a bench-chosen truth table; results scored against a model.
module tb_truth_table_sweeper;
    import truth_table_sweeper_pkg::*;

    localparam logic [7:0] EXP_TT = 8'h10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SETTLE_CYCLES=2; instance Z: SETTLE_CYCLES=0.
    logic       start_a = 1'b0, abort_a = 1'b0, f_a;
    logic       a_a, b_a, c_a, busy_a, done_a, pass_a, ffv_a;
    logic [3:0] fc_a;
    logic [2:0] ffvec_a;
    state_t     st_a;
    logic [7:0] ft_a = 8'h10;

    logic       start_z = 1'b0, abort_z = 1'b0, f_z;
    logic       a_z, b_z, c_z, busy_z, done_z, pass_z, ffv_z;
    logic [3:0] fc_z;
    logic [2:0] ffvec_z;
    state_t     st_z;
    logic [7:0] ft_z = 8'h10;

    assign f_a = ft_a[{a_a, b_a, c_a}];
    assign f_z = ft_z[{a_z, b_z, c_z}];

    truth_table_sweeper #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .f_in(f_a),
        .a_out(a_a), .b_out(b_a), .c_out(c_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_count(fc_a), .first_fail_valid(ffv_a),
        .first_fail_vec(ffvec_a), .dbg_state(st_a)
    );

    truth_table_sweeper #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .abort(abort_z), .f_in(f_z),
        .a_out(a_z), .b_out(b_z), .c_out(c_z), .busy(busy_z), .done(done_z),
        .pass(pass_z), .fail_count(fc_z), .first_fail_valid(ffv_z),
        .first_fail_vec(ffvec_z), .dbg_state(st_z)
    );

    int checks = 0;
    int errors = 0;

    // Expected result word: {pass, fail_count[3:0], first_fail_valid, first_fail_vec[2:0]}
    logic [8:0] exp_a[$];
    logic [8:0] exp_z[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Score a whole sweep from the truth tables: one mismatch per differing vector.
    function automatic logic [8:0] model(input logic [7:0] ft);
        int         n = 0;
        logic       seen = 1'b0;
        logic [2:0] first = 3'd0;
        for (int v = 0; v < 8; v++) begin
            if (ft[v] != EXP_TT[v]) begin
                if (!seen) first = 3'(v);
                seen = 1'b1;
                n++;
            end
        end
        return {(n == 0), 4'(n), seen, first};
    endfunction

    // Monitor A: vector sequence while busy, sweep length and results on done.
    int   bc_a = 0;
    logic pb_a = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            bc_a = 0;
            pb_a = 1'b0;
        end else begin
            if (busy_a) begin
                chk("vec_seq_a", {29'd0, a_a, b_a, c_a}, 32'(bc_a / 3));
                bc_a++;
            end
            if (done_a) begin
                if (exp_a.size() == 0) begin
                    flag("unexpected_done_a");
                end else begin
                    e = exp_a.pop_front();
                    chk("sweep_len_a", 32'(bc_a), 32'd24);
                    chk("pass_a", {31'd0, pass_a}, {31'd0, e[8]});
                    chk("fail_count_a", {28'd0, fc_a}, {28'd0, e[7:4]});
                    chk("ffv_a", {31'd0, ffv_a}, {31'd0, e[3]});
                    if (e[3]) chk("ffvec_a", {29'd0, ffvec_a}, {29'd0, e[2:0]});
                    chk("done_abc_a", {29'd0, a_a, b_a, c_a}, 32'd0);
                end
                bc_a = 0;
            end else if (pb_a && !busy_a) begin
                bc_a = 0;
            end
            pb_a = busy_a;
        end
    end

    // Monitor Z: each vector held one cycle.
    int   bc_z = 0;
    logic pb_z = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            bc_z = 0;
            pb_z = 1'b0;
        end else begin
            if (busy_z) begin
                chk("vec_seq_z", {29'd0, a_z, b_z, c_z}, 32'(bc_z));
                bc_z++;
            end
            if (done_z) begin
                if (exp_z.size() == 0) begin
                    flag("unexpected_done_z");
                end else begin
                    e = exp_z.pop_front();
                    chk("sweep_len_z", 32'(bc_z), 32'd8);
                    chk("pass_z", {31'd0, pass_z}, {31'd0, e[8]});
                    chk("fail_count_z", {28'd0, fc_z}, {28'd0, e[7:4]});
                    chk("ffv_z", {31'd0, ffv_z}, {31'd0, e[3]});
                    if (e[3]) chk("ffvec_z", {29'd0, ffvec_z}, {29'd0, e[2:0]});
                end
                bc_z = 0;
            end else if (pb_z && !busy_z) begin
                bc_z = 0;
            end
            pb_z = busy_z;
        end
    end

    task automatic issue_a(input logic [7:0] ft);
        ft_a = ft;
        exp_a.push_back(model(ft));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic issue_z(input logic [7:0] ft);
        ft_z = ft;
        exp_z.push_back(model(ft));
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) flag("timeout_done_a");
    endtask

    task automatic wait_done_z(input int budget);
        int n = 0;
        while (!done_z && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_z) flag("timeout_done_z");
    endtask

    task automatic wait_vec_a(input logic [2:0] v, input int budget);
        int n = 0;
        while ({a_a, b_a, c_a} != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ({a_a, b_a, c_a} != v) flag("timeout_vec_a");
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass_a}, 32'd0);
        chk({tag, "_fail_count"}, {28'd0, fc_a}, 32'd0);
        chk({tag, "_ffv"}, {31'd0, ffv_a}, 32'd0);
        chk({tag, "_ffvec"}, {29'd0, ffvec_a}, 32'd0);
        chk({tag, "_abc"}, {29'd0, a_a, b_a, c_a}, 32'd0);
        chk({tag, "_state"}, 32'(st_a), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] ft;

        repeat (3) @(negedge clk);
        check_reset_a("reset_a");
        chk("reset_z_busy", {31'd0, busy_z}, 32'd0);
        chk("reset_z_fail_count", {28'd0, fc_z}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct stage, incorrect stage tied low, stage tied high with no settle.
        issue_a(8'h10);
        wait_done_a(40);
        issue_a(8'h00);
        wait_done_a(40);
        issue_z(8'hFF);
        wait_done_z(20);

        // Abort during the hold of vector 3 keeps the partial score.
        repeat (2) @(negedge clk);
        issue_a(8'hFF);
        wait_vec_a(3'd3, 40);
        chk("abort_pre_state", 32'(st_a), 32'(HOLD));
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        void'(exp_a.pop_back());
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_done", {31'd0, done_a}, 32'd0);
        chk("abort_abc", {29'd0, a_a, b_a, c_a}, 32'd0);
        chk("abort_pass", {31'd0, pass_a}, 32'd0);
        chk("abort_fail_count", {28'd0, fc_a}, 32'd3);
        chk("abort_ffv", {31'd0, ffv_a}, 32'd1);
        chk("abort_ffvec", {29'd0, ffvec_a}, 32'd0);
        chk("abort_state", 32'(st_a), 32'(IDLE));
        repeat (30) @(negedge clk);
        issue_a(8'h10);
        chk("restart_fail_count", {28'd0, fc_a}, 32'd0);
        chk("restart_ffv", {31'd0, ffv_a}, 32'd0);
        wait_done_a(40);

        // Reset asserted during the sample cycle of vector 5.
        repeat (2) @(negedge clk);
        issue_a(8'h5A);
        wait_vec_a(3'd5, 40);
        repeat (2) @(negedge clk);
        chk("rst_pre_state", 32'(st_a), 32'(SAMPLE));
        rst_n = 1'b0;
        #1;
        check_reset_a("midrst_a");
        void'(exp_a.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("post_rst_state", 32'(st_a), 32'(IDLE));

        // Start held through a sweep is ignored; every vector fails (saturation edge).
        ft_a = 8'hEF;
        exp_a.push_back(model(8'hEF));
        start_a = 1'b1;
        repeat (20) @(negedge clk);
        start_a = 1'b0;
        wait_done_a(20);
        // Restart straight from DONE clears the previous score next cycle.
        issue_a(8'h10);
        chk("redo_fail_count", {28'd0, fc_a}, 32'd0);
        chk("redo_ffv", {31'd0, ffv_a}, 32'd0);
        chk("redo_busy", {31'd0, busy_a}, 32'd1);
        wait_done_a(40);
        issue_a(8'hEF);
        chk("redo_pass", {31'd0, pass_a}, 32'd0);
        wait_done_a(40);

        // Random truth tables on both instances.
        for (int i = 0; i < 8; i++) begin
            ft = 8'($urandom);
            issue_a(ft);
            wait_done_a(40);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            ft = 8'($urandom);
            issue_z(ft);
            wait_done_z(20);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("pending_a", 32'(exp_a.size()), 32'd0);
        chk("pending_z", 32'(exp_z.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
